// File: rtl/lbus_master_if.sv
// Core-side request/response handshake and peripheral local-bus signals of lbus_master.
// The master modport is the initiator's view; slave is the core plus responder side.
interface lbus_master_if #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [AWIDTH-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic              resp_ready;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;

  logic              sel;
  logic [AWIDTH-1:0] addr;
  logic [2:0]        we;
  logic [XLEN-1:0]   wdata;
  logic [XLEN-1:0]   rdata;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready, rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output sel, addr, we, wdata
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready, rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  sel, addr, we, wdata
  );
endinterface

// File: rtl/lbus_master.sv
// Local-bus initiator: one load/store per request, registered bus cycle held RDLAT+1
// cycles, byte/half extraction with sign/zero extension on the returned word.
module lbus_master #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 8,
  parameter int RDLAT  = 0
) (
  input  logic         clk,
  input  logic         rst,
  lbus_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam logic [1:0] LAST_CNT = 2'(RDLAT);

  state_t     state, state_d;
  logic [1:0] cnt, cnt_d;
  logic       accept;
  logic       bad;
  logic       last;

  logic       l_write;
  logic       l_unsigned;
  logic [1:0] l_size;
  logic [1:0] l_lane;

  function automatic logic [XLEN-1:0] extract(
    input logic [XLEN-1:0] w,
    input logic [1:0]      size,
    input logic            uns,
    input logic [1:0]      lane
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{lane, 3'b000} +: 8];
    h = w[{lane[1], 4'b0000} +: 16];
    case (size)
      2'b00:   extract = uns ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      2'b01:   extract = uns ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: extract = w;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d        = state;
    cnt_d          = cnt;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    bad = (bus.req_size == 2'b11) ||
          ((bus.req_size == 2'b01) && bus.req_addr[0]) ||
          ((bus.req_size == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    accept = (state == IDLE) && bus.req_valid;
    last   = (state == ACCESS) && (cnt == LAST_CNT);
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_d = bad ? RESP : ACCESS;
      end
      ACCESS: begin
        if (cnt == LAST_CNT) begin
          state_d = RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt + 2'd1;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus outputs are loaded at acceptance and cleared on the capture edge, so they
  // stay constant for the whole held access without re-deriving them from state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      l_write        <= 1'b0;
      l_unsigned     <= 1'b0;
      l_size         <= '0;
      l_lane         <= '0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
      bus.sel        <= 1'b0;
      bus.addr       <= '0;
      bus.we         <= '0;
      bus.wdata      <= '0;
    end else if (accept) begin
      l_write        <= bus.req_write;
      l_unsigned     <= bus.req_unsigned;
      l_size         <= bus.req_size;
      l_lane         <= bus.req_addr[1:0];
      bus.resp_rdata <= '0;
      bus.resp_err   <= bad;
      if (!bad) begin
        bus.sel   <= 1'b1;
        bus.addr  <= bus.req_addr;
        bus.we    <= {bus.req_write, bus.req_size};
        bus.wdata <= bus.req_wdata;
      end
    end else if (last) begin
      bus.sel   <= 1'b0;
      bus.addr  <= '0;
      bus.we    <= '0;
      bus.wdata <= '0;
      if (!l_write) bus.resp_rdata <= extract(bus.rdata, l_size, l_unsigned, l_lane);
    end
  end

endmodule

// File: tb/tb_lbus_master.sv
// Bench for lbus_master: RDLAT=0 and RDLAT=2 instances share one stimulus path and a
// memory-backed responder; expectations come from a byte-level reference memory.
module tb_lbus_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lbus_master_if #(.XLEN(32), .AWIDTH(8)) b0 ();
  lbus_master_if #(.XLEN(32), .AWIDTH(8)) b1 ();

  lbus_master #(.XLEN(32), .AWIDTH(8), .RDLAT(0)) dut0 (.clk(clk), .rst(rst), .bus(b0.master));
  lbus_master #(.XLEN(32), .AWIDTH(8), .RDLAT(2)) dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  logic        dsel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, resp_ready = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic [7:0]  req_addr = 8'h00;
  logic [31:0] req_wdata = '0;
  logic [31:0] junk = '0;

  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];

  assign b0.req_valid    = req_valid & ~dsel;
  assign b1.req_valid    = req_valid & dsel;
  assign b0.req_write    = req_write;    assign b1.req_write    = req_write;
  assign b0.req_size     = req_size;     assign b1.req_size     = req_size;
  assign b0.req_unsigned = req_unsigned; assign b1.req_unsigned = req_unsigned;
  assign b0.req_addr     = req_addr;     assign b1.req_addr     = req_addr;
  assign b0.req_wdata    = req_wdata;    assign b1.req_wdata    = req_wdata;
  assign b0.resp_ready   = resp_ready & ~dsel;
  assign b1.resp_ready   = resp_ready & dsel;
  assign b0.rdata = b0.sel ? mem[b0.addr[7:2]] : junk;
  assign b1.rdata = b1.sel ? mem[b1.addr[7:2]] : junk;

  logic        m_req_ready, m_resp_valid, m_resp_err, m_sel;
  logic [31:0] m_resp_rdata, m_wdata;
  logic [7:0]  m_addr;
  logic [2:0]  m_we;
  assign m_req_ready  = dsel ? b1.req_ready  : b0.req_ready;
  assign m_resp_valid = dsel ? b1.resp_valid : b0.resp_valid;
  assign m_resp_err   = dsel ? b1.resp_err   : b0.resp_err;
  assign m_resp_rdata = dsel ? b1.resp_rdata : b0.resp_rdata;
  assign m_sel        = dsel ? b1.sel        : b0.sel;
  assign m_addr       = dsel ? b1.addr       : b0.addr;
  assign m_we         = dsel ? b1.we         : b0.we;
  assign m_wdata      = dsel ? b1.wdata      : b0.wdata;

  // Responder: word memory, byte/half lanes taken from the low bits of wdata.
  always @(posedge clk) begin
    logic [31:0] t;
    junk <= $urandom;
    if (rst) begin
      for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
    end else if (m_sel && m_we[2]) begin
      t = mem[m_addr[7:2]];
      case (m_we[1:0])
        2'b00:   t[8*m_addr[1:0] +: 8] = m_wdata[7:0];
        2'b01:   t[16*m_addr[1] +: 16] = m_wdata[15:0];
        default: t = m_wdata;
      endcase
      mem[m_addr[7:2]] <= t;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset();
    chk("rst_req_ready", m_req_ready, 1);
    chk("rst_resp_valid", m_resp_valid, 0);
    chk("rst_resp_err", m_resp_err, 0);
    chk("rst_resp_rdata", m_resp_rdata, 0);
    chk("rst_bus", {m_sel, m_addr, m_we, m_wdata}, 0);
  endtask

  task automatic txn(input logic w, input logic [1:0] sz, input logic u, input logic [7:0] a,
                     input logic [31:0] wd, input int unsigned stall, input logic pend);
    logic        err, got;
    logic [31:0] exp_rd, word, v;
    int unsigned lat, sel_cnt, resp_cyc, lane;
    lane   = int'(a) % 4;
    err    = (sz == 2'd3) || (sz == 2'd1 && lane % 2 != 0) || (sz == 2'd2 && lane != 0);
    word   = ref_mem[a / 4];
    exp_rd = 0;
    if (!err && !w) begin
      if (sz == 2'd0) begin
        v = (word >> (8 * lane)) % 256;
        if (!u && v >= 128) v = v + 32'hFFFF_FF00;
        exp_rd = v;
      end else if (sz == 2'd1) begin
        v = (word >> (8 * lane)) % 65536;
        if (!u && v >= 32768) v = v + 32'hFFFF_0000;
        exp_rd = v;
      end else begin
        exp_rd = word;
      end
    end
    if (!err && w) begin
      if (sz == 2'd0)
        word = (word & ~(32'hFF << (8 * lane))) | ((wd % 256) << (8 * lane));
      else if (sz == 2'd1)
        word = (word & ~(32'hFFFF << (8 * lane))) | ((wd % 65536) << (8 * lane));
      else
        word = wd;
      ref_mem[a / 4] = word;
    end
    lat = dsel ? 2 : 0;

    @(negedge clk);
    req_write = w; req_size = sz; req_unsigned = u; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    chk("req_ready_idle", m_req_ready, 1);
    @(posedge clk);
    #1 req_valid = 1'b0;

    got = 1'b0; sel_cnt = 0; resp_cyc = 0;
    for (int c = 1; c <= 12 && !got; c++) begin
      @(negedge clk);
      if (m_sel) begin
        sel_cnt++;
        chk("bus_addr", m_addr, a);
        chk("bus_we", m_we, {w, sz});
        chk("bus_wdata", m_wdata, wd);
      end else begin
        chk("bus_idle", {m_addr, m_we, m_wdata}, 0);
      end
      chk("req_ready_busy", m_req_ready, 0);
      if (m_resp_valid) begin
        got = 1'b1;
        resp_cyc = c;
      end
    end
    chk("resp_latency", resp_cyc, err ? 1 : lat + 2);
    chk("sel_cycles", sel_cnt, err ? 0 : lat + 1);
    chk("resp_rdata", m_resp_rdata, exp_rd);
    chk("resp_err", m_resp_err, err);

    for (int s = 0; s < int'(stall); s++) begin
      req_valid = pend;
      @(negedge clk);
      chk("stall_valid", m_resp_valid, 1);
      chk("stall_rdata", m_resp_rdata, exp_rd);
      chk("stall_err", m_resp_err, err);
      chk("stall_no_accept", {m_req_ready, m_sel}, 0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("post_req_ready", m_req_ready, 1);
    chk("post_resp_valid", m_resp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
    ref_mem[4] = 32'h0000_9C00;
    ref_mem[0] = 32'h8001_0000;
    repeat (2) @(negedge clk);
    dsel = 1'b0; #1 chk_reset();
    dsel = 1'b1; #1 chk_reset();
    dsel = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    txn(1'b1, 2'd2, 1'b0, 8'h20, 32'h0000_00A5, 0, 1'b0);
    txn(1'b0, 2'd0, 1'b0, 8'h11, 32'h0, 0, 1'b0);
    txn(1'b0, 2'd0, 1'b1, 8'h11, 32'h0, 1, 1'b0);
    txn(1'b0, 2'd2, 1'b0, 8'h06, 32'h0, 0, 1'b0);
    txn(1'b0, 2'd3, 1'b0, 8'h00, 32'h0, 0, 1'b0);
    txn(1'b0, 2'd2, 1'b0, 8'h20, 32'h0, 5, 1'b1);
    txn(1'b0, 2'd1, 1'b1, 8'h12, 32'h0, 0, 1'b0);
    req_valid = 1'b0;

    dsel = 1'b1;
    txn(1'b0, 2'd1, 1'b0, 8'h02, 32'h0, 0, 1'b0);
    txn(1'b1, 2'd0, 1'b0, 8'h33, 32'h1234_56F0, 2, 1'b0);
    txn(1'b0, 2'd0, 1'b0, 8'h33, 32'h0, 0, 1'b0);

    // Reset in the middle of a held access drops it without a response.
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 8'h08; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_sel", m_sel, 1);
    rst = 1'b1;
    #1 chk_reset();
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("no_stale_resp", {m_resp_valid, m_sel}, 0);
    end
    txn(1'b0, 2'd2, 1'b0, 8'h08, 32'h0, 0, 1'b0);

    for (int d = 0; d < 2; d++) begin
      dsel = d[0];
      for (int n = 0; n < 40; n++) begin
        logic [7:0] a;
        logic [1:0] sz;
        a  = 8'($urandom);
        sz = 2'($urandom);
        if ($urandom_range(3) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom_range(3), (n != 39) && ($urandom_range(1) == 1));
      end
      req_valid = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbus_master.md
# lbus_master

Local-bus initiator for the peripheral register space. It accepts single load/store requests from the core's memory-access stage over a valid/ready handshake. It drives one `sel/addr/we/wdata` access onto the peripheral local bus, captures `rdata`, and returns a byte-extracted, sign/zero-extended response. Every register block on that bus (GPIO and others) is a responder to this block.

## Interface
Parameters:
- `XLEN`, 32, data width (from `core_general.vh`)
- `AWIDTH`, 8, local-bus address width
- `RDLAT`, 0, extra wait cycles `sel` is held before `rdata` is sampled (0..3)

Ports:
- `clk`  in  1  global clock
- `rst`  in  1  asynchronous, active-high reset
- `req_valid`  in  1  request present
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `req_write`  in  1  1 = store, 0 = load
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal
- `req_unsigned`  in  1  load zero-extends when 1, sign-extends when 0
- `req_addr`  in  AWIDTH  byte address
- `req_wdata`  in  XLEN  store data, right-aligned
- `resp_valid`  out  1  response present
- `resp_ready`  in  1  response consumed when `resp_valid & resp_ready`
- `resp_rdata`  out  XLEN  extended load data; 0 for stores and errors
- `resp_err`  out  1  misaligned address or illegal size
- `sel`  out  1  local-bus select
- `addr`  out  AWIDTH  local-bus address
- `we`  out  3  `{write, size[1:0]}`: 1_00 byte, 1_01 half, 1_10 word; `we[2]`=0 for reads
- `wdata`  out  XLEN  local-bus write data
- `rdata`  in  XLEN  local-bus read data, word-aligned, combinational from responder

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - `req_ready`=1.
  - On handshake, latch all request fields.
  - Illegal size, or misalignment (half with `addr[0]`=1; word with `addr[1:0]`≠0), goes directly to RESP with `resp_err`=1 and `resp_rdata`=0. No bus cycle is issued.
  - Otherwise go to ACCESS.
- ACCESS:
  - `sel`=1.
  - `addr` = latched address.
  - `we` = `{req_write, req_size}` for stores; `{1'b0, req_size}` for loads.
  - `wdata` = latched `req_wdata`, passed through unshifted. Responders take byte data from `wdata[7:0]` and half data from `wdata[15:0]`.
  - Held for `RDLAT`+1 cycles (wait counter). On the last cycle, loads capture `rdata` into the response register. Then go to RESP.
- Load extraction from the word-aligned `rdata`:
  - Byte: lane selected by `addr[1:0]`, bits [8k+7:8k].
  - Half: lane selected by `addr[1]`.
  - Word: unchanged.
  - Extension: sign-extend from bit 7 or bit 15 unless `req_unsigned`; `req_unsigned` is ignored for word.
- RESP: `resp_valid`=1, held stable until `resp_ready`; then go to IDLE.
- Outside ACCESS: `sel`=0, `we`=000, `addr`=0, `wdata`=0. All bus outputs are registered.
- Only one outstanding request at a time. `req_ready`=0 in ACCESS and RESP.

## Timing
- Reset (asynchronous, any state, including mid-ACCESS): state IDLE, wait counter 0. Outputs: `req_ready`=1, `resp_valid`=0, `resp_err`=0, `resp_rdata`=0, `sel`=0, `addr`=0, `we`=000, `wdata`=0. An interrupted access is dropped and produces no response.
- Handshake in cycle N → `sel` high in cycles N+1 … N+1+RDLAT → `resp_valid` high from cycle N+2+RDLAT.
- Error request accepted in cycle N → `resp_valid` from N+1; `sel` never asserted.
- `resp_ready` high in the first RESP cycle → `req_ready`=1 the next cycle. Minimum back-to-back period is 3+RDLAT cycles.
- `resp_ready` held low: `resp_valid`, `resp_rdata` and `resp_err` stay constant; no new request is accepted.
- Changes on `rdata` outside the capture cycle have no effect.

## Test plan
- Word store, addr 0x20, wdata 0x0000_00A5 → exactly one cycle `sel`=1, `addr`=0x20, `we`=110, `wdata`=0x0000_00A5; `resp_valid` 2 cycles after handshake with `resp_err`=0.
- Byte load, addr 0x11, signed, `rdata`=0x0000_9C00 during ACCESS → `we`=000, `resp_rdata`=0xFFFF_FF9C. Same request unsigned → 0x0000_009C.
- Half load, addr 0x02, RDLAT=2, `rdata`=0x8001_0000 → `sel` high 3 cycles; signed result 0xFFFF_8001.
- Misaligned word load at 0x06, and size 11 at 0x00 → no `sel` pulse; `resp_err`=1, `resp_rdata`=0.
- Back-pressure: `resp_ready`=0 for 5 cycles with a second request pending → response stable; second request accepted only in the cycle after the response handshake.
- Assert `rst` during ACCESS → all outputs at reset values immediately; after release, a new word load completes normally with no stale response.
